// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache to L2 memory arbiter.
// Holds the FSM state encoding, the grant-source encoding and the bus widths.
package mem_arbiter_pkg;

   localparam int ADDR_W  = 16;
   localparam int BURST_W = 128;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT_I,
      ARB_GRANT_D
   } arb_state_t;

   typedef enum logic {
      ARB_SRC_I,
      ARB_SRC_D
   } arb_src_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational next-grant picker for the memory arbiter.
// The result is only meaningful when at least one cache is requesting.
module mem_arbiter_select
   import mem_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = 0,
   parameter int MAX_STREAK = 4,
   parameter int STREAK_W   = $clog2(MAX_STREAK + 1)
) (
   input  logic                req_i,
   input  logic                req_d,
   input  arb_src_t            last_grant,
   input  logic [STREAK_W-1:0] streak,
   output arb_src_t            grant
);

   // A lone requester always wins; ties are settled by round-robin or by
   // D priority, with I forced in once D has used up its streak.
   always_comb begin
      grant = ARB_SRC_I;
      if (req_d && !req_i) begin
         grant = ARB_SRC_D;
      end else if (req_d && req_i) begin
         if (PRIO_MODE == 0) begin
            grant = (last_grant == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
         end else begin
            grant = (streak == STREAK_W'(MAX_STREAK)) ? ARB_SRC_I : ARB_SRC_D;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one L2 burst port between the I-cache and D-cache miss ports.
// One owner per transaction; the grant is held until l2_resp or until the owner aborts.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = 0,
   parameter int MAX_STREAK = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_pmem_read,
   input  logic               if_pmem_write,
   input  logic [ADDR_W-1:0]  if_pmem_address,
   input  logic [BURST_W-1:0] if_pmem_wdata,
   output logic               if_pmem_resp,
   output logic [BURST_W-1:0] if_pmem_rdata,
   input  logic               mem_pmem_read,
   input  logic               mem_pmem_write,
   input  logic [ADDR_W-1:0]  mem_pmem_address,
   input  logic [BURST_W-1:0] mem_pmem_wdata,
   output logic               mem_pmem_resp,
   output logic [BURST_W-1:0] mem_pmem_rdata,
   output logic               l2_read,
   output logic               l2_write,
   output logic [ADDR_W-1:0]  l2_address,
   output logic [BURST_W-1:0] l2_wdata,
   input  logic               l2_resp,
   input  logic [BURST_W-1:0] l2_rdata
);

   localparam int STREAK_W = $clog2(MAX_STREAK + 1);

   arb_state_t          state_q;
   arb_state_t          state_d;
   arb_src_t            last_grant_q;
   arb_src_t            pick;
   logic [STREAK_W-1:0] streak_q;
   logic                req_i;
   logic                req_d;

   assign req_i = if_pmem_read | if_pmem_write;
   assign req_d = mem_pmem_read | mem_pmem_write;

   mem_arbiter_select #(
      .PRIO_MODE (PRIO_MODE),
      .MAX_STREAK(MAX_STREAK),
      .STREAK_W  (STREAK_W)
   ) u_select (
      .req_i     (req_i),
      .req_d     (req_d),
      .last_grant(last_grant_q),
      .streak    (streak_q),
      .grant     (pick)
   );

   // Grant states always fall back to IDLE, so the owning cache gets one
   // quiet cycle to drop its strobe before it can be granted again.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (req_i || req_d) begin
               state_d = (pick == ARB_SRC_D) ? ARB_GRANT_D : ARB_GRANT_I;
            end
         end
         ARB_GRANT_I: begin
            if (l2_resp || !req_i) begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT_D: begin
            if (l2_resp || !req_d) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      l2_read       = 1'b0;
      l2_write      = 1'b0;
      l2_address    = '0;
      l2_wdata      = '0;
      if_pmem_resp  = 1'b0;
      mem_pmem_resp = 1'b0;
      case (state_q)
         ARB_GRANT_I: begin
            l2_read      = if_pmem_read;
            l2_write     = if_pmem_write;
            l2_address   = if_pmem_address;
            l2_wdata     = if_pmem_wdata;
            if_pmem_resp = l2_resp;
         end
         ARB_GRANT_D: begin
            l2_read       = mem_pmem_read;
            l2_write      = mem_pmem_write;
            l2_address    = mem_pmem_address;
            l2_wdata      = mem_pmem_wdata;
            mem_pmem_resp = l2_resp;
         end
         default: begin
         end
      endcase
   end

   assign if_pmem_rdata  = l2_rdata;
   assign mem_pmem_rdata = l2_rdata;

   // The streak only counts D wins that actually made I wait; any I win,
   // or any IDLE cycle without an I request, clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= ARB_SRC_I;
         streak_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARB_IDLE) begin
            if (req_i || req_d) begin
               last_grant_q <= pick;
            end
            if (!req_i || pick == ARB_SRC_I) begin
               streak_q <= '0;
            end else if (streak_q != STREAK_W'(MAX_STREAK)) begin
               streak_q <= streak_q + STREAK_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a per-cycle vector table on a round-robin
// instance plus hand-written sequences on a D-priority instance (MAX_STREAK=2).
module tb_mem_arbiter;

   localparam logic [127:0] WI = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] WD = 128'hDEADBEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
   localparam logic [127:0] RD = 128'hCAFEF00D_1234_5678_9ABC_DEF0_0BAD_F00D;

   logic         clk;
   logic         rst;
   logic         if_read, if_write, mem_read, mem_write;
   logic [15:0]  if_addr, mem_addr;
   logic [127:0] if_wdata, mem_wdata, l2_rdata;
   logic         l2_resp0, l2_resp1;

   logic         if_resp0, mem_resp0, l2_read0, l2_write0;
   logic [127:0] if_rdata0, mem_rdata0, l2_wdata0;
   logic [15:0]  l2_address0;
   logic         if_resp1, mem_resp1, l2_read1, l2_write1;
   logic [127:0] if_rdata1, mem_rdata1, l2_wdata1;
   logic [15:0]  l2_address1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ir, iw;
      logic [15:0] ia;
      logic        mr, mw;
      logic [15:0] ma;
      logic        resp;
      logic        er, ew;
      logic [15:0] ea;
      logic [127:0] ewd;
      logic        eir, emr;
   } vec_t;

   vec_t vecs[$];

   mem_arbiter #(.PRIO_MODE(0), .MAX_STREAK(4)) dut0 (
      .clk(clk), .rst(rst),
      .if_pmem_read(if_read), .if_pmem_write(if_write), .if_pmem_address(if_addr),
      .if_pmem_wdata(if_wdata), .if_pmem_resp(if_resp0), .if_pmem_rdata(if_rdata0),
      .mem_pmem_read(mem_read), .mem_pmem_write(mem_write), .mem_pmem_address(mem_addr),
      .mem_pmem_wdata(mem_wdata), .mem_pmem_resp(mem_resp0), .mem_pmem_rdata(mem_rdata0),
      .l2_read(l2_read0), .l2_write(l2_write0), .l2_address(l2_address0),
      .l2_wdata(l2_wdata0), .l2_resp(l2_resp0), .l2_rdata(l2_rdata)
   );

   mem_arbiter #(.PRIO_MODE(1), .MAX_STREAK(2)) dut1 (
      .clk(clk), .rst(rst),
      .if_pmem_read(if_read), .if_pmem_write(if_write), .if_pmem_address(if_addr),
      .if_pmem_wdata(if_wdata), .if_pmem_resp(if_resp1), .if_pmem_rdata(if_rdata1),
      .mem_pmem_read(mem_read), .mem_pmem_write(mem_write), .mem_pmem_address(mem_addr),
      .mem_pmem_wdata(mem_wdata), .mem_pmem_resp(mem_resp1), .mem_pmem_rdata(mem_rdata1),
      .l2_read(l2_read1), .l2_write(l2_write1), .l2_address(l2_address1),
      .l2_wdata(l2_wdata1), .l2_resp(l2_resp1), .l2_rdata(l2_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A cache may never raise read and write together.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(if_read && if_write)) else $error("[TB] I-cache read and write together");
         assert (!(mem_read && mem_write)) else $error("[TB] D-cache read and write together");
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, need finish)");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mk(input logic ir, iw, input logic [15:0] ia,
                               input logic mr, mw, input logic [15:0] ma, input logic resp,
                               input logic er, ew, input logic [15:0] ea,
                               input logic [127:0] ewd, input logic eir, emr);
      vec_t v;
      v.ir = ir; v.iw = iw; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.resp = resp;
      v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd; v.eir = eir; v.emr = emr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, need %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if_read  = v.ir;
      if_write = v.iw;
      if_addr  = v.ia;
      mem_read = v.mr;
      mem_write = v.mw;
      mem_addr = v.ma;
      l2_resp0 = v.resp;
   endtask

   task automatic waitStrobe1(input string name, output bit found);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!l2_read1 && n < 12) begin
         @(negedge clk); #1;
         n++;
      end
      found = l2_read1;
      if (!found) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: no l2_read strobe within 12 cycles (got 0, need 1)", name);
      end
   endtask

   task automatic serve1(input string name, input logic [15:0] expAddr, input logic expI);
      bit found;
      waitStrobe1(name, found);
      if (found) begin
         checkOutput({name, " addr"}, l2_address1, expAddr);
         l2_resp1 = 1'b1;
         #1;
         checkOutput({name, " if_resp"}, if_resp1, expI);
         checkOutput({name, " mem_resp"}, mem_resp1, !expI);
         @(posedge clk); #1;
         l2_resp1 = 1'b0;
      end
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      if_read = 0; if_write = 0; mem_read = 0; mem_write = 0;
      if_addr = '0; mem_addr = '0;
      if_wdata = WI; mem_wdata = WD; l2_rdata = RD;
      l2_resp0 = 0; l2_resp1 = 0;

      // reset state: outputs quiet even with requests and a stray response
      repeat (2) @(negedge clk);
      if_read = 1; if_addr = 16'h0040; l2_resp0 = 1;
      #1;
      checkOutput("reset l2_read", l2_read0, 0);
      checkOutput("reset l2_address", l2_address0, 0);
      checkOutput("reset l2_wdata", l2_wdata0, 0);
      checkOutput("reset if_resp", if_resp0, 0);
      checkOutput("reset mem_resp", mem_resp0, 0);
      if_read = 0; l2_resp0 = 0;
      @(negedge clk);
      rst = 1'b0;

      // I-only read with a non-owner D request ignored
      vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0, 1,0,16'h0040, WI, 0,0));
      vecs.push_back(mk(1,0,16'h0040, 1,0,16'h0500, 0, 1,0,16'h0040, WI, 0,0));
      vecs.push_back(mk(1,0,16'h0040, 1,0,16'h0500, 0, 1,0,16'h0040, WI, 0,0));
      vecs.push_back(mk(1,0,16'h0040, 1,0,16'h0500, 1, 1,0,16'h0040, WI, 1,0));
      vecs.push_back(mk(0,0,16'h0040, 0,0,16'h0500, 0, 0,0,16'h0000, 0, 0,0));
      // tie with last_grant=I: D first, one idle cycle, then I
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0, 1,0,16'h0200, WD, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1, 1,0,16'h0200, WD, 0,1));
      vecs.push_back(mk(1,0,16'h0100, 0,0,16'h0200, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 0,0,16'h0200, 0, 1,0,16'h0100, WI, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 0,0,16'h0200, 1, 1,0,16'h0100, WI, 1,0));
      vecs.push_back(mk(0,0,16'h0100, 0,0,16'h0200, 0, 0,0,16'h0000, 0, 0,0));
      // D write burst forwarded unchanged
      vecs.push_back(mk(0,0,16'h0000, 0,1,16'h1230, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(0,0,16'h0000, 0,1,16'h1230, 0, 0,1,16'h1230, WD, 0,0));
      vecs.push_back(mk(0,0,16'h0000, 0,1,16'h1230, 0, 0,1,16'h1230, WD, 0,0));
      vecs.push_back(mk(0,0,16'h0000, 0,1,16'h1230, 1, 0,1,16'h1230, WD, 0,1));
      vecs.push_back(mk(0,0,16'h0000, 0,0,16'h1230, 0, 0,0,16'h0000, 0, 0,0));
      // I aborts, then a stray l2_resp in IDLE
      vecs.push_back(mk(1,0,16'h0300, 0,0,16'h0000, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(1,0,16'h0300, 0,0,16'h0000, 0, 1,0,16'h0300, WI, 0,0));
      vecs.push_back(mk(0,0,16'h0300, 0,0,16'h0000, 0, 0,0,16'h0300, WI, 0,0));
      vecs.push_back(mk(0,0,16'h0300, 0,0,16'h0000, 1, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0, 0,0,16'h0000, 0, 0,0));
      // tie after the aborted I grant still goes to D
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0, 0,0,16'h0000, 0, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0, 1,0,16'h0200, WD, 0,0));
      vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1, 1,0,16'h0200, WD, 0,1));
      vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0, 0,0,16'h0000, 0, 0,0));

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d l2_read", i), l2_read0, vecs[i].er);
         checkOutput($sformatf("row%0d l2_write", i), l2_write0, vecs[i].ew);
         checkOutput($sformatf("row%0d l2_address", i), l2_address0, vecs[i].ea);
         checkOutput($sformatf("row%0d l2_wdata", i), l2_wdata0, vecs[i].ewd);
         checkOutput($sformatf("row%0d if_resp", i), if_resp0, vecs[i].eir);
         checkOutput($sformatf("row%0d mem_resp", i), mem_resp0, vecs[i].emr);
         if (vecs[i].eir) checkOutput($sformatf("row%0d if_rdata", i), if_rdata0, RD);
         if (vecs[i].emr) checkOutput($sformatf("row%0d mem_rdata", i), mem_rdata0, RD);
      end

      // D priority with streak cap 2 while I keeps requesting: D,D,I,D,D,I
      @(negedge clk);
      rst = 1'b1;
      l2_resp0 = 0;
      if_read = 1; if_addr = 16'h0100;
      mem_read = 1; mem_addr = 16'h0200;
      @(negedge clk);
      rst = 1'b0;
      serve1("prio g1", 16'h0200, 0);
      serve1("prio g2", 16'h0200, 0);
      serve1("prio g3", 16'h0100, 1);
      serve1("prio g4", 16'h0200, 0);
      serve1("prio g5", 16'h0200, 0);
      serve1("prio g6", 16'h0100, 1);

      // async reset in the middle of a D grant, then a pending I request
      if_read = 0;
      waitStrobe1("areset grant D", found);
      if (found) begin
         checkOutput("areset pre addr", l2_address1, 16'h0200);
         if_read = 1;
         l2_resp1 = 1;
         #1;
         checkOutput("areset pre mem_resp", mem_resp1, 1);
         rst = 1'b1;
         mem_read = 0;
         #1;
         checkOutput("areset l2_read", l2_read1, 0);
         checkOutput("areset l2_address", l2_address1, 0);
         checkOutput("areset l2_wdata", l2_wdata1, 0);
         checkOutput("areset mem_resp", mem_resp1, 0);
         checkOutput("areset if_resp", if_resp1, 0);
         l2_resp1 = 0;
         #1;
         rst = 1'b0;
         serve1("areset then I", 16'h0100, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
